// File: rtl/cpu_mem_responder_if.sv
// ---------------------------------------------------------------------------
// cpu_mem_responder_if
//   Load/store bus between a processor core (master) and the data-memory
//   responder (slave). Single-beat requests, one-cycle ack completion.
//
//   req        master -> slave  request, sampled by the slave when idle
//   we         master -> slave  1 = write, 0 = read
//   addr       master -> slave  word address
//   wdata      master -> slave  write data
//   ack        slave  -> master one-cycle completion pulse
//   rdata      slave  -> master read data, valid with ack, held afterwards
//   err        slave  -> master out-of-range flag, valid with ack
//   busy       slave  -> master transaction in flight
//   txn_count  slave  -> master saturating completed-transaction count
// ---------------------------------------------------------------------------
interface cpu_mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;
  logic [15:0]       txn_count;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, err, busy, txn_count
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata, err, busy, txn_count
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// ---------------------------------------------------------------------------
// cpu_mem_responder
//   Slow data memory for the processor load/store port. A request is latched
//   in IDLE, held for WAIT_CYCLES wait states, performed at the WAIT->RESP
//   edge and acknowledged for one cycle in RESP.
//
//   clk    rising-edge clock
//   pcrst  asynchronous active-low reset
//   bus    cpu_mem_responder_if slave side (req/we/addr/wdata in,
//          ack/rdata/err/busy/txn_count out)
//
//   Latency: capture at edge E -> ack high in the cycle after E+WAIT_CYCLES+1.
//   Minimum request period is WAIT_CYCLES+3 cycles.
// ---------------------------------------------------------------------------
module cpu_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 200,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 pcrst,
  cpu_mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);
  // One extra bit so DEPTH == 2^ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ack_q;
  logic              err_q;
  logic              busy_q;
  logic [DATA_W-1:0] rdata_q;
  logic [15:0]       txn_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic in_range;
  logic do_access;

  assign in_range  = ({1'b0, addr_q} < DEPTH_LIM);
  // The access happens on the edge that leaves WAIT with an expired counter.
  assign do_access = (state == S_WAIT) && (wait_cnt == 4'd0);

  // NOTE: the memory array has no reset branch; clearing every word would
  // turn it into a bank of flops instead of a RAM. Because reset forces the
  // state to IDLE asynchronously, a write still in WAIT can never land.
  always_ff @(posedge clk) begin
    if (do_access && we_q && in_range) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge pcrst) begin
    if (!pcrst) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdata_q  <= '0;
      txn_q    <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            we_q     <= bus.we;
            addr_q   <= bus.addr;
            wdata_q  <= bus.wdata;
            wait_cnt <= WAIT_INIT;
            busy_q   <= 1'b1;
            state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            ack_q <= 1'b1;
            state <= S_RESP;
            if (!in_range) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else if (!we_q) begin
              rdata_q <= mem[addr_q];
            end
          end
        end

        S_RESP: begin
          ack_q  <= 1'b0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
          if (txn_q != 16'hFFFF) begin
            txn_q <= txn_q + 16'd1;
          end
          state  <= S_IDLE;
        end

        // NOTE: the default arm makes the unused encoding recover to IDLE
        // with quiet outputs instead of locking up.
        default: begin
          ack_q  <= 1'b0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.rdata     = rdata_q;
  assign bus.txn_count = txn_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_responder
//   Two responders: dut1 with the default two wait states, dut0 with none.
//   Stimulus pushes the expected response of each request into a per-DUT
//   queue; a monitor pops and compares whenever ack is seen.
// ---------------------------------------------------------------------------
module tb_cpu_mem_responder;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          ack_cyc;
  } exp_t;

  logic clk;
  logic pcrst;
  int   cyc;
  int   checks;
  int   failures;

  exp_t q1[$];
  exp_t q0[$];

  cpu_mem_responder_if #(.ADDR_W(8), .DATA_W(16)) bus1 ();
  cpu_mem_responder_if #(.ADDR_W(8), .DATA_W(16)) bus0 ();

  cpu_mem_responder #(
    .ADDR_W(8), .DATA_W(16), .DEPTH(200), .WAIT_CYCLES(2)
  ) dut1 (
    .clk   (clk),
    .pcrst (pcrst),
    .bus   (bus1.slave)
  );

  cpu_mem_responder #(
    .ADDR_W(8), .DATA_W(16), .DEPTH(200), .WAIT_CYCLES(0)
  ) dut0 (
    .clk   (clk),
    .pcrst (pcrst),
    .bus   (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus1.ack === 1'b1) begin
      if (q1.size() == 0) begin
        check("d1_unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("d1_rdata", {16'd0, bus1.rdata}, {16'd0, e.rdata});
        check("d1_err", {31'd0, bus1.err}, {31'd0, e.err});
        check("d1_ack_cycle", cyc, e.ack_cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (bus0.ack === 1'b1) begin
      if (q0.size() == 0) begin
        check("d0_unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("d0_rdata", {16'd0, bus0.rdata}, {16'd0, e.rdata});
        check("d0_err", {31'd0, bus0.err}, {31'd0, e.err});
        check("d0_ack_cycle", cyc, e.ack_cyc);
      end
    end
  end

  // One request with req high for a single capture edge. Called and
  // returning #1 after a rising edge with the selected DUT idle.
  task automatic run_txn(input bit d0, input logic w, input logic [7:0] a,
                         input logic [15:0] wd, input logic [15:0] exp_rd,
                         input logic exp_err);
    int   wc;
    exp_t e;
    wc = d0 ? 0 : 2;
    if (d0) begin
      bus0.req = 1'b1; bus0.we = w; bus0.addr = a; bus0.wdata = wd;
    end else begin
      bus1.req = 1'b1; bus1.we = w; bus1.addr = a; bus1.wdata = wd;
    end
    @(posedge clk); #1;
    e.rdata   = exp_rd;
    e.err     = exp_err;
    e.ack_cyc = cyc + wc + 1;
    // Garbage on the request lines after capture must be ignored.
    if (d0) begin
      q0.push_back(e);
      bus0.req = 1'b0; bus0.we = ~w; bus0.addr = 8'hFF; bus0.wdata = 16'hDEAD;
    end else begin
      q1.push_back(e);
      bus1.req = 1'b0; bus1.we = ~w; bus1.addr = 8'hFF; bus1.wdata = 16'hDEAD;
    end
    repeat (wc + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lows;
    exp_t e;
    checks   = 0;
    failures = 0;
    pcrst    = 1'b0;
    bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = 8'h00; bus1.wdata = 16'h0000;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 8'h00; bus0.wdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1 pcrst = 1'b1;
    @(posedge clk); #1;

    // Reset state of both responders
    check("rst_ack",   {31'd0, bus1.ack},  32'd0);
    check("rst_err",   {31'd0, bus1.err},  32'd0);
    check("rst_busy",  {31'd0, bus1.busy}, 32'd0);
    check("rst_rdata", {16'd0, bus1.rdata}, 32'd0);
    check("rst_txn",   {16'd0, bus1.txn_count}, 32'd0);
    check("rst_d0_busy", {31'd0, bus0.busy}, 32'd0);
    check("rst_d0_txn",  {16'd0, bus0.txn_count}, 32'd0);

    // Write BEEF to 0x10: rdata stays at its reset value
    run_txn(1'b0, 1'b1, 8'h10, 16'hBEEF, 16'h0000, 1'b0);
    check("txn_after_write", {16'd0, bus1.txn_count}, 32'd1);

    // Read it back; rdata must hold afterwards
    run_txn(1'b0, 1'b0, 8'h10, 16'h0000, 16'hBEEF, 1'b0);
    check("txn_after_read", {16'd0, bus1.txn_count}, 32'd2);
    repeat (2) @(posedge clk);
    #1;
    check("rdata_hold", {16'd0, bus1.rdata}, 32'h0000BEEF);

    // Out of range: addr 0xC8 == DEPTH
    run_txn(1'b0, 1'b1, 8'hC8, 16'h7777, 16'h0000, 1'b1);
    run_txn(1'b0, 1'b0, 8'hC8, 16'h0000, 16'h0000, 1'b1);
    check("err_low_after_ack", {31'd0, bus1.err}, 32'd0);
    run_txn(1'b0, 1'b0, 8'h10, 16'h0000, 16'hBEEF, 1'b0);
    check("txn_after_oor", {16'd0, bus1.txn_count}, 32'd5);

    // Back-to-back with req held high: write 1234 then read 0x05
    bus1.req = 1'b1; bus1.we = 1'b1; bus1.addr = 8'h05; bus1.wdata = 16'h1234;
    @(posedge clk); #1;
    e.rdata = 16'hBEEF; e.err = 1'b0; e.ack_cyc = cyc + 3;
    q1.push_back(e);
    bus1.wdata = 16'h5555;
    lows = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus1.busy === 1'b0) lows++;
    end
    bus1.we = 1'b0;
    @(posedge clk); #1;
    e.rdata = 16'h1234; e.err = 1'b0; e.ack_cyc = cyc + 3;
    q1.push_back(e);
    bus1.req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus1.busy === 1'b0) lows++;
    end
    @(posedge clk); #1;
    check("b2b_idle_gap", lows, 32'd1);
    check("txn_after_b2b", {16'd0, bus1.txn_count}, 32'd7);

    // Reset during WAIT drops the pending write of AAAA
    bus1.req = 1'b1; bus1.we = 1'b1; bus1.addr = 8'h10; bus1.wdata = 16'hAAAA;
    @(posedge clk); #1;
    bus1.req = 1'b0;
    @(posedge clk); #1;
    pcrst = 1'b0;
    #1;
    check("midrst_ack",   {31'd0, bus1.ack},  32'd0);
    check("midrst_err",   {31'd0, bus1.err},  32'd0);
    check("midrst_busy",  {31'd0, bus1.busy}, 32'd0);
    check("midrst_rdata", {16'd0, bus1.rdata}, 32'd0);
    check("midrst_txn",   {16'd0, bus1.txn_count}, 32'd0);
    repeat (3) @(posedge clk);
    #1 pcrst = 1'b1;
    @(posedge clk); #1;
    run_txn(1'b0, 1'b0, 8'h10, 16'h0000, 16'hBEEF, 1'b0);
    check("txn_after_midrst", {16'd0, bus1.txn_count}, 32'd1);

    // Zero wait states and counter saturation
    force dut0.txn_q = 16'hFFFD;
    @(posedge clk); #1;
    release dut0.txn_q;
    @(posedge clk); #1;
    check("d0_preload", {16'd0, bus0.txn_count}, 32'h0000FFFD);
    run_txn(1'b1, 1'b1, 8'h00, 16'h0001, 16'h0000, 1'b0);
    check("d0_txn_fffe", {16'd0, bus0.txn_count}, 32'h0000FFFE);
    run_txn(1'b1, 1'b0, 8'h00, 16'h0000, 16'h0001, 1'b0);
    check("d0_txn_ffff", {16'd0, bus0.txn_count}, 32'h0000FFFF);
    run_txn(1'b1, 1'b0, 8'hFF, 16'h0000, 16'h0000, 1'b1);
    check("d0_txn_sat", {16'd0, bus0.txn_count}, 32'h0000FFFF);

    // Every expected response must have been seen
    repeat (3) @(posedge clk);
    #1;
    check("d1_pending", q1.size(), 32'd0);
    check("d0_pending", q0.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Data-memory responder sitting on the processor's load/store port; the processor core is the initiator, this block is the target.
- Accepts single-beat read/write requests over a req/ack handshake, inserts a programmable number of wait states, and returns read data, an error flag and a completed-transaction count.
- Gives the CPU a realistic slow memory so stall logic can be exercised in integrated simulation.

Parameters:
- ADDR_W, 8, address width in bits.
- DATA_W, 16, data word width in bits.
- DEPTH, 200, number of implemented words; addresses >= DEPTH are out of range. Must be <= 2^ADDR_W.
- WAIT_CYCLES, 2, wait states inserted between capture and response; legal range 0..15.

Ports:
- clk  in  1  system clock, rising-edge.
- pcrst  in  1  asynchronous active-low reset (0 = reset, 1 = run).
- req  in  1  initiator request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; qualified by req.
- addr  in  ADDR_W  word address; qualified by req.
- wdata  in  DATA_W  write data; qualified by req & we.
- ack  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read data; valid while ack=1, holds value until next read completes.
- err  out  1  out-of-range flag; valid while ack=1, else 0.
- busy  out  1  1 in WAIT or RESP.
- txn_count  out  16  completed transactions, saturates at 16'hFFFF.

Behaviour:
- Reset (pcrst=0, async): state=IDLE, ack=0, err=0, busy=0, rdata=0, txn_count=0, wait counter=0, latched request cleared. Memory array is NOT cleared; contents are undefined until written.
- States: IDLE, WAIT, RESP.
- IDLE: on a clk edge with req=1, latch we/addr/wdata, load counter=WAIT_CYCLES, go to WAIT. With req=0, stay in IDLE.
- WAIT: if counter!=0, decrement it and stay in WAIT. If counter==0, perform the access and go to RESP.
- Access at the WAIT->RESP edge:
  - In range, write: mem[addr]<=wdata. rdata is unchanged.
  - In range, read: rdata<=mem[addr].
  - Out of range (addr>=DEPTH): no memory update, rdata<=0, err<=1.
- RESP: ack=1 for exactly one cycle. txn_count increments at the RESP->IDLE edge, saturating. The next state is always IDLE.
- Latency: if capture occurs at edge E, ack is high during the cycle following edge E+WAIT_CYCLES+1. With WAIT_CYCLES=0, ack rises one edge after capture.
- Back-to-back requests: req held high through ack is re-sampled in IDLE. Minimum request period is WAIT_CYCLES+3 cycles.
- req changes after capture: the transaction is already latched and always completes. There is no abort. Changes on we/addr/wdata during WAIT/RESP are ignored.
- busy = (state!=IDLE).
- Reset mid-operation: the latched request is dropped. A write not yet performed (reset before the WAIT->RESP edge) never reaches memory, and no ack is issued.
- Undefined state encodings recover to IDLE.

Test Plan:
- After reset release, write 16'hBEEF to addr 8'h10 (req=1 for one cycle) -> ack one cycle, 3 edges after capture, err=0, txn_count=1.
- Read addr 8'h10 -> ack with rdata=16'hBEEF, err=0, txn_count=2; rdata still BEEF two cycles later.
- Write then read addr 8'hC8 (=DEPTH) -> each response has err=1 and rdata=0; a subsequent read of addr 8'h10 still returns BEEF; txn_count +2.
- Hold req=1 continuously while alternating write 16'h1234 / read of addr 8'h05 -> ack pulses spaced exactly 5 cycles apart; the read returns 16'h1234; busy low exactly one cycle between transactions.
- Start a write of 16'hAAAA to addr 8'h10, assert pcrst=0 during WAIT -> ack never asserts, all outputs 0, txn_count=0; a read of addr 8'h10 after release returns 16'hBEEF.
- Build with WAIT_CYCLES=0, force txn_count near saturation (65535 transactions or a preload via force) -> ack follows capture by one edge; txn_count stops at 16'hFFFF.
